// File: rtl/alu_execute.sv
// Multi-cycle ALU execute stage between register-file reads and write-back.
// Define ALU_MUL_EN to build the 8-iteration shift-add multiply for opcode 111.
module alu_execute (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_dest_addr,
  input  logic [7:0] i_operand_a,
  input  logic [7:0] i_operand_b,
  output logic       o_busy,
  output logic       o_write_enable,
  output logic [1:0] o_write_reg_addr,
  output logic [7:0] o_write_data,
  output logic       o_carry,
  output logic       o_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
`ifdef ALU_MUL_EN
    S_MUL  = 2'd2
`else
    S_DROP = 2'd3
`endif
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t     state;
  state_t     next_state;
  logic       load_alu;
  logic [7:0] alu_result;
  logic       alu_carry;

`ifdef ALU_MUL_EN
  logic        load_mul;
  logic        mul_last;
  logic [2:0]  mul_count;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [1:0]  mul_dest;
  logic [15:0] mul_acc;
  logic [15:0] mul_acc_next;

  // Each iteration adds the multiplicand shifted by the current multiplier bit index.
  assign mul_acc_next = mul_acc + (mul_b[mul_count] ? ({8'd0, mul_a} << mul_count) : 16'd0);
  assign mul_last     = (mul_count == 3'd7);
`endif

  // Single-cycle operations are computed straight from the operands at accept.
  always_comb begin
    alu_result = 8'd0;
    alu_carry  = 1'b0;
    case (i_opcode)
      OP_ADD: {alu_carry, alu_result} = {1'b0, i_operand_a} + {1'b0, i_operand_b};
      OP_SUB: begin
        alu_result = i_operand_a - i_operand_b;
        alu_carry  = (i_operand_a < i_operand_b);
      end
      OP_AND: alu_result = i_operand_a & i_operand_b;
      OP_OR:  alu_result = i_operand_a | i_operand_b;
      OP_XOR: alu_result = i_operand_a ^ i_operand_b;
      OP_SHL: begin
        alu_result = {i_operand_a[6:0], 1'b0};
        alu_carry  = i_operand_a[7];
      end
      OP_SHR: begin
        alu_result = {1'b0, i_operand_a[7:1]};
        alu_carry  = i_operand_a[0];
      end
      default: begin
        alu_result = 8'd0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state     = state;
    load_alu       = 1'b0;
    o_busy         = 1'b1;
    o_write_enable = 1'b0;
`ifdef ALU_MUL_EN
    load_mul       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_opcode == OP_MUL) begin
`ifdef ALU_MUL_EN
            load_mul   = 1'b1;
            next_state = S_MUL;
`else
            next_state = S_DROP;
`endif
          end else begin
            load_alu   = 1'b1;
            next_state = S_WB;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (mul_last) next_state = S_WB;
      end
`else
      S_DROP: next_state = S_IDLE;
`endif
      S_WB: begin
        o_write_enable = 1'b1;
        next_state     = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Write-back result, address and flags only change on the edge that enters WB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_write_reg_addr <= 2'd0;
      o_write_data     <= 8'd0;
      o_carry          <= 1'b0;
      o_zero           <= 1'b0;
`ifdef ALU_MUL_EN
      mul_count        <= 3'd0;
      mul_a            <= 8'd0;
      mul_b            <= 8'd0;
      mul_dest         <= 2'd0;
      mul_acc          <= 16'd0;
`endif
    end else begin
      if (load_alu) begin
        o_write_reg_addr <= i_dest_addr;
        o_write_data     <= alu_result;
        o_carry          <= alu_carry;
        o_zero           <= (alu_result == 8'd0);
      end
`ifdef ALU_MUL_EN
      if (load_mul) begin
        mul_count <= 3'd0;
        mul_a     <= i_operand_a;
        mul_b     <= i_operand_b;
        mul_dest  <= i_dest_addr;
        mul_acc   <= 16'd0;
      end else if (state == S_MUL) begin
        mul_acc   <= mul_acc_next;
        mul_count <= mul_count + 3'd1;
        if (mul_last) begin
          o_write_reg_addr <= mul_dest;
          o_write_data     <= mul_acc_next[7:0];
          o_carry          <= (mul_acc_next[15:8] != 8'd0);
          o_zero           <= (mul_acc_next[7:0] == 8'd0);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute; MUL checks build only with ALU_MUL_EN.
module tb_alu_execute;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_start;
  logic [2:0] i_opcode;
  logic [1:0] i_dest_addr;
  logic [7:0] i_operand_a;
  logic [7:0] i_operand_b;
  logic       o_busy;
  logic       o_write_enable;
  logic [1:0] o_write_reg_addr;
  logic [7:0] o_write_data;
  logic       o_carry;
  logic       o_zero;

  int total = 0;
  int bad   = 0;

  alu_execute dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_start          (i_start),
    .i_opcode         (i_opcode),
    .i_dest_addr      (i_dest_addr),
    .i_operand_a      (i_operand_a),
    .i_operand_b      (i_operand_b),
    .o_busy           (o_busy),
    .o_write_enable   (o_write_enable),
    .o_write_reg_addr (o_write_reg_addr),
    .o_write_data     (o_write_data),
    .o_carry          (o_carry),
    .o_zero           (o_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present a start for one edge (the accept edge); returns #1 after that edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] dest,
                               input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    i_start     = 1'b1;
    i_opcode    = op;
    i_dest_addr = dest;
    i_operand_a = a;
    i_operand_b = b;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWriteBack(input string tag, input logic [1:0] addr, input logic [7:0] data,
                                input logic carry, input logic zero);
    checkOutput({tag, "_we"},    16'(o_write_enable),   16'd1);
    checkOutput({tag, "_addr"},  16'(o_write_reg_addr), 16'(addr));
    checkOutput({tag, "_data"},  16'(o_write_data),     16'(data));
    checkOutput({tag, "_carry"}, 16'(o_carry),          16'(carry));
    checkOutput({tag, "_zero"},  16'(o_zero),           16'(zero));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  16'(o_busy),           16'd0);
    checkOutput({tag, "_we"},    16'(o_write_enable),   16'd0);
    checkOutput({tag, "_addr"},  16'(o_write_reg_addr), 16'd0);
    checkOutput({tag, "_data"},  16'(o_write_data),     16'd0);
    checkOutput({tag, "_carry"}, 16'(o_carry),          16'd0);
    checkOutput({tag, "_zero"},  16'(o_zero),           16'd0);
  endtask

  initial begin
    int we_count;
    int cycles;
    logic [7:0] wb_data;

    reset_n     = 1'b0;
    i_start     = 1'b0;
    i_opcode    = 3'd0;
    i_dest_addr = 2'd0;
    i_operand_a = 8'd0;
    i_operand_b = 8'd0;
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // ADD wrapping to zero
    applyStimulus(3'b000, 2'd2, 8'hFF, 8'h01);
    checkOutput("add_busy", 16'(o_busy), 16'd1);
    checkWriteBack("add_ff01", 2'd2, 8'h00, 1'b1, 1'b1);
    stepCycle();
    checkOutput("add_idle_busy", 16'(o_busy), 16'd0);
    checkOutput("add_idle_we", 16'(o_write_enable), 16'd0);
    checkOutput("add_hold_data", 16'(o_write_data), 16'h00);
    checkOutput("add_hold_carry", 16'(o_carry), 16'd1);

    applyStimulus(3'b000, 2'd0, 8'h12, 8'h34);
    checkWriteBack("add_nc", 2'd0, 8'h46, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(3'b001, 2'd1, 8'h10, 8'h20);
    checkWriteBack("sub_borrow", 2'd1, 8'hF0, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(3'b001, 2'd3, 8'h20, 8'h20);
    checkWriteBack("sub_eq", 2'd3, 8'h00, 1'b0, 1'b1);
    stepCycle();

    applyStimulus(3'b110, 2'd3, 8'h81, 8'h00);
    checkWriteBack("shr", 2'd3, 8'h40, 1'b1, 1'b0);
    stepCycle();

    applyStimulus(3'b101, 2'd1, 8'h80, 8'h00);
    checkWriteBack("shl", 2'd1, 8'h00, 1'b1, 1'b1);
    stepCycle();

    applyStimulus(3'b010, 2'd2, 8'hF0, 8'h0F);
    checkWriteBack("and", 2'd2, 8'h00, 1'b0, 1'b1);
    stepCycle();

    applyStimulus(3'b011, 2'd0, 8'h30, 8'h03);
    checkWriteBack("or", 2'd0, 8'h33, 1'b0, 1'b0);
    stepCycle();

    applyStimulus(3'b100, 2'd1, 8'h5A, 8'hA5);
    checkWriteBack("xor", 2'd1, 8'hFF, 1'b0, 1'b0);
    stepCycle();

    // Start held through WB must not be accepted on the edge that leaves WB
    applyStimulus(3'b000, 2'd2, 8'h01, 8'h01);
    i_start = 1'b1;
    checkWriteBack("hold_start", 2'd2, 8'h02, 1'b0, 1'b0);
    stepCycle();
    i_start = 1'b0;
    checkOutput("hold_start_busy", 16'(o_busy), 16'd0);
    checkOutput("hold_start_we", 16'(o_write_enable), 16'd0);

    // Reset while in WB aborts the write-back
    applyStimulus(3'b000, 2'd3, 8'h07, 8'h08);
    checkOutput("rst_wb_we_before", 16'(o_write_enable), 16'd1);
    @(negedge clk);
    reset_n = 1'b0;
    stepCycle();
    checkAllZero("rst_wb");
    @(negedge clk);
    reset_n = 1'b1;

    // Start together with reset: reset wins
    @(negedge clk);
    reset_n  = 1'b0;
    i_start  = 1'b1;
    i_opcode = 3'b000;
    stepCycle();
    i_start = 1'b0;
    checkAllZero("rst_start");
    @(negedge clk);
    reset_n = 1'b1;
    stepCycle();
    checkOutput("rst_start_busy_after", 16'(o_busy), 16'd0);

`ifdef ALU_MUL_EN
    // 0x0F x 0x11: write-back should appear after edge 8 counted from accept
    applyStimulus(3'b111, 2'd1, 8'h0F, 8'h11);
    checkOutput("mul1_busy", 16'(o_busy), 16'd1);
    checkOutput("mul1_we_early", 16'(o_write_enable), 16'd0);
    cycles = 0;
    while (!o_write_enable && cycles < 20) begin
      stepCycle();
      cycles++;
    end
    checkOutput("mul1_latency", 16'(cycles), 16'd8);
    checkWriteBack("mul1", 2'd1, 8'hFF, 1'b0, 1'b0);
    stepCycle();
    checkOutput("mul1_done_busy", 16'(o_busy), 16'd0);

    applyStimulus(3'b111, 2'd2, 8'h20, 8'h10);
    cycles = 0;
    while (!o_write_enable && cycles < 20) begin
      stepCycle();
      cycles++;
    end
    checkOutput("mul2_latency", 16'(cycles), 16'd8);
    checkWriteBack("mul2", 2'd2, 8'h00, 1'b1, 1'b1);
    stepCycle();

    // Start pulses and operand changes during MUL are ignored
    applyStimulus(3'b111, 2'd3, 8'h0F, 8'h11);
    we_count = 0;
    wb_data  = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        i_start     = 1'b1;
        i_opcode    = 3'b000;
        i_dest_addr = 2'd0;
        i_operand_a = 8'(c);
        i_operand_b = 8'h55;
      end else begin
        i_start = 1'b0;
      end
      stepCycle();
      if (o_write_enable) begin
        we_count++;
        wb_data = o_write_data;
        checkOutput("mul_ign_addr", 16'(o_write_reg_addr), 16'd3);
      end
    end
    checkOutput("mul_ign_count", 16'(we_count), 16'd1);
    checkOutput("mul_ign_data", 16'(wb_data), 16'hFF);

    // Reset at cycle 4 of a MUL: no write-back, outputs cleared
    applyStimulus(3'b111, 2'd2, 8'h0F, 8'h11);
    we_count = 0;
    for (int c = 1; c <= 3; c++) begin
      stepCycle();
      if (o_write_enable) we_count++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    stepCycle();
    checkAllZero("mul_rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      stepCycle();
      if (o_write_enable) we_count++;
    end
    checkOutput("mul_rst_no_we", 16'(we_count), 16'd0);
    applyStimulus(3'b000, 2'd1, 8'h22, 8'h11);
    checkWriteBack("after_mul_rst_add", 2'd1, 8'h33, 1'b0, 1'b0);
    stepCycle();
`else
    // Without the multiplier, opcode 111 is a one-cycle no-op with flags untouched
    applyStimulus(3'b000, 2'd2, 8'hFF, 8'h01);
    checkWriteBack("pre_nomul", 2'd2, 8'h00, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(3'b111, 2'd1, 8'h03, 8'h03);
    checkOutput("nomul_busy", 16'(o_busy), 16'd1);
    checkOutput("nomul_we", 16'(o_write_enable), 16'd0);
    we_count = 0;
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      if (o_write_enable) we_count++;
    end
    checkOutput("nomul_busy_after", 16'(o_busy), 16'd0);
    checkOutput("nomul_we_count", 16'(we_count), 16'd0);
    checkOutput("nomul_carry", 16'(o_carry), 16'd1);
    checkOutput("nomul_zero", 16'(o_zero), 16'd1);
    checkOutput("nomul_data", 16'(o_write_data), 16'h00);
    checkOutput("nomul_addr", 16'(o_write_reg_addr), 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
